// File: rtl/pixel_pattern_gen.sv
// Test-pattern source slaved to an external sync controller: follows H/V sync edges,
// tracks raster position and emits solid / colour-bar / checker / gradient pixels.
module pixel_pattern_gen #(
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int BAR_WIDTH   = 80
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        H_SYNC,
  input  logic        V_SYNC,
  input  logic [1:0]  MODE,
  input  logic [11:0] COLOR,
  output logic [3:0]  R_OUT,
  output logic [3:0]  G_OUT,
  output logic [3:0]  B_OUT,
  output logic        H_SYNC_OUT,
  output logic        V_SYNC_OUT,
  output logic        ACTIVE
);

  localparam logic [9:0] H_START_L = 10'(H_ACT_START);
  localparam logic [9:0] H_LAST_L  = 10'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [9:0] V_START_L = 10'(V_ACT_START);
  localparam logic [9:0] V_END_L   = 10'(V_ACT_START + V_ACTIVE);
  localparam int         BAR_CW    = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    V_BLANK    = 2'd1,
    H_BLANK    = 2'd2,
    ACT_LINE   = 2'd3
  } state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [3:0] expand(input logic b);
    return b ? 4'hF : 4'h0;
  endfunction

  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] bits;
    case (idx)
      3'd0:    bits = 3'b111;
      3'd1:    bits = 3'b110;
      3'd2:    bits = 3'b011;
      3'd3:    bits = 3'b010;
      3'd4:    bits = 3'b101;
      3'd5:    bits = 3'b100;
      3'd6:    bits = 3'b001;
      default: bits = 3'b000;
    endcase
    return {expand(bits[2]), expand(bits[1]), expand(bits[0])};
  endfunction

  function automatic logic [11:0] pattern_rgb(
    input logic [1:0]  mode,
    input logic [11:0] color,
    input logic [2:0]  bar,
    input logic        chk,
    input logic [3:0]  x_hi,
    input logic [3:0]  y_mid,
    input logic [3:0]  fcnt
  );
    case (mode)
      2'b00:   return color;
      2'b01:   return bar_rgb(bar);
      2'b10:   return chk ? 12'hFFF : 12'h000;
      default: return {x_hi, y_mid, fcnt};
    endcase
  endfunction

  // Stage p0: sync history, raster counters, FSM, per-frame settings
  logic        hs_p0_q, vs_p0_q;
  logic        h_fall, v_fall;
  logic [9:0]  h_pos_q, h_pos_d;
  logic [9:0]  v_pos_q, v_pos_d;
  state_t      state_q, state_d;
  logic [BAR_CW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] color_q, color_d;

  // Edge compares the registered sample (prev) against the incoming one (cur).
  assign h_fall = hs_p0_q & ~H_SYNC;
  assign v_fall = vs_p0_q & ~V_SYNC;

  always_comb begin
    h_pos_d = h_fall ? 10'd0 : sat_inc(h_pos_q);
    v_pos_d = v_pos_q;
    if (v_fall) begin
      v_pos_d = 10'd0;
    end else if (h_fall) begin
      v_pos_d = sat_inc(v_pos_q);
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    color_d     = color_q;
    if (v_fall) begin
      frame_cnt_d = frame_cnt_q + 4'd1;
      mode_d      = MODE;
      color_d     = COLOR;
    end
  end

  // State is paired with the pixel whose position sits in h_pos_q/v_pos_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: state_d = WAIT_FRAME;
      V_BLANK: begin
        if (v_pos_q == V_START_L) state_d = H_BLANK;
      end
      H_BLANK: begin
        if (v_pos_q == V_END_L) begin
          state_d = V_BLANK;
        end else if (h_pos_d == H_START_L) begin
          state_d = ACT_LINE;
        end
      end
      ACT_LINE: begin
        if (h_pos_q == H_LAST_L) state_d = H_BLANK;
      end
      default: state_d = WAIT_FRAME;
    endcase
    if (v_fall) state_d = V_BLANK;
  end

  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if ((state_d == ACT_LINE) && (state_q != ACT_LINE)) begin
      bar_cnt_d = '0;
      bar_idx_d = 3'd0;
    end else if (state_q == ACT_LINE) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BAR_CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_p0_q     <= 1'b1;
      vs_p0_q     <= 1'b1;
      h_pos_q     <= 10'd0;
      v_pos_q     <= 10'd0;
      state_q     <= WAIT_FRAME;
      bar_cnt_q   <= '0;
      bar_idx_q   <= 3'd0;
      frame_cnt_q <= 4'd0;
      mode_q      <= 2'b00;
      color_q     <= 12'h000;
    end else begin
      hs_p0_q     <= H_SYNC;
      vs_p0_q     <= V_SYNC;
      h_pos_q     <= h_pos_d;
      v_pos_q     <= v_pos_d;
      state_q     <= state_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      color_q     <= color_d;
    end
  end

  // Stage p1: pixel colour, active flag and delayed syncs
  logic [9:0]  x_pos, y_pos;
  logic        unused_pix_bits;
  logic        hs_p1_q, vs_p1_q;
  logic        active_p1_q, active_p1_d;
  logic [11:0] rgb_p1_q, rgb_p1_d;

  assign x_pos = h_pos_q - H_START_L;
  assign y_pos = v_pos_q - V_START_L;
  assign unused_pix_bits = ^{x_pos[4:0], y_pos[4:0], y_pos[9]};

  always_comb begin
    active_p1_d = (state_q == ACT_LINE);
    rgb_p1_d    = 12'h000;
    if (active_p1_d) begin
      rgb_p1_d = pattern_rgb(mode_q, color_q, bar_idx_q, x_pos[5] ^ y_pos[5],
                             x_pos[9:6], y_pos[8:5], frame_cnt_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      active_p1_q <= 1'b0;
      rgb_p1_q    <= 12'h000;
    end else begin
      hs_p1_q     <= hs_p0_q;
      vs_p1_q     <= vs_p0_q;
      active_p1_q <= active_p1_d;
      rgb_p1_q    <= rgb_p1_d;
    end
  end

  assign R_OUT      = rgb_p1_q[11:8];
  assign G_OUT      = rgb_p1_q[7:4];
  assign B_OUT      = rgb_p1_q[3:0];
  assign ACTIVE     = active_p1_q;
  assign H_SYNC_OUT = hs_p1_q;
  assign V_SYNC_OUT = vs_p1_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Directed bench for pixel_pattern_gen on a scaled raster: 120-clk lines (H low 12),
// 14-line frames (V low 2), active window 80x8 starting at (20,4), 10-pixel bars.
`timescale 1ns/1ps
module tb_pixel_pattern_gen;
  localparam int HS = 20, HA = 80, VS = 4, VA = 8, BW = 10;
  localparam int LINE = 120, H_LOW = 12, LINES = 14, V_LOW = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        H_SYNC = 1'b1;
  logic        V_SYNC = 1'b1;
  logic [1:0]  MODE = 2'b00;
  logic [11:0] COLOR = 12'h000;
  logic [3:0]  R_OUT, G_OUT, B_OUT;
  logic        H_SYNC_OUT, V_SYNC_OUT, ACTIVE;

  int checks = 0;
  int errors = 0;

  bit          allow_v, running, hs_prev, vs_prev;
  int          fcnt;
  logic [1:0]  mode_l;
  logic [11:0] color_l;
  logic        e_act, e_hs, e_vs;
  logic [11:0] e_rgb;
  int          e_x, e_y;
  int          bad, act_cnt;
  logic [11:0] line0 [HA];

  pixel_pattern_gen #(
    .H_ACT_START(HS), .H_ACTIVE(HA), .V_ACT_START(VS), .V_ACTIVE(VA), .BAR_WIDTH(BW)
  ) dut (
    .CLK(CLK), .RST(RST), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .MODE(MODE), .COLOR(COLOR),
    .R_OUT(R_OUT), .G_OUT(G_OUT), .B_OUT(B_OUT),
    .H_SYNC_OUT(H_SYNC_OUT), .V_SYNC_OUT(V_SYNC_OUT), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bar_rgb(input int b);
    case (b % 8)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y);
    case (mode_l)
      2'b00: return color_l;
      2'b01: return bar_rgb(x / BW);
      2'b10: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return {4'((x >> 6) & 15), 4'((y >> 5) & 15), 4'(fcnt)};
    endcase
  endfunction

  task automatic model_reset();
    running = 0; fcnt = 0; hs_prev = 1; vs_prev = 1;
    mode_l = 2'b00; color_l = 12'h000;
    e_act = 1'b0; e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_x = -1; e_y = -1;
  endtask

  task automatic start_phase();
    bad = 0; act_cnt = 0;
  endtask

  // One pixel clock: drive sample (L,c), then compare outputs against the previous sample.
  task automatic step(input int L, input int c);
    logic hs, vs, act;
    logic [11:0] rgb;
    int x, y;
    hs = (c < H_LOW) ? 1'b0 : 1'b1;
    vs = (allow_v && L < V_LOW) ? 1'b0 : 1'b1;
    H_SYNC = hs;
    V_SYNC = vs;
    if (vs_prev && !vs) begin
      running = 1; fcnt = (fcnt + 1) % 16; mode_l = MODE; color_l = COLOR;
    end
    x = c - HS;
    y = L - VS;
    act = running && x >= 0 && x < HA && y >= 0 && y < VA;
    rgb = act ? model_rgb(x, y) : 12'h000;
    hs_prev = hs;
    vs_prev = vs;
    @(posedge CLK);
    @(negedge CLK);
    if (ACTIVE !== e_act || {R_OUT, G_OUT, B_OUT} !== e_rgb ||
        H_SYNC_OUT !== e_hs || V_SYNC_OUT !== e_vs) bad++;
    if (ACTIVE === 1'b1) act_cnt++;
    if (e_act && e_y == 0) line0[e_x] = {R_OUT, G_OUT, B_OUT};
    e_act = act; e_rgb = rgb; e_hs = hs; e_vs = vs; e_x = x; e_y = y;
  endtask

  task automatic run(input int l0, input int c0, input int l1);
    for (int l = l0; l < l1; l++)
      for (int c = (l == l0) ? c0 : 0; c < LINE; c++) step(l, c);
  endtask

  initial begin
    model_reset();
    allow_v = 0;
    #2 RST = 1'b1;
    #1;
    check("rst_rgb", 32'({R_OUT, G_OUT, B_OUT}), 32'h0);
    check("rst_active", 32'(ACTIVE), 32'h0);
    check("rst_hs_out", 32'(H_SYNC_OUT), 32'h1);
    check("rst_vs_out", 32'(V_SYNC_OUT), 32'h1);
    check("rst_state", 32'(dut.state_q), 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Lines with H_SYNC only: generator must stay blank
    start_phase();
    run(5, 0, 8);
    check("nov_bad", 32'(bad), 32'h0);
    check("nov_active", 32'(act_cnt), 32'h0);

    // Frame 1: solid A5C
    allow_v = 1;
    MODE = 2'b00; COLOR = 12'hA5C;
    start_phase();
    run(0, 0, LINES);
    check("solid_bad", 32'(bad), 32'h0);
    check("solid_active_cnt", 32'(act_cnt), 32'd640);
    check("solid_px0", 32'(line0[0]), 32'hA5C);
    check("solid_px79", 32'(line0[79]), 32'hA5C);

    // Frame 2: colour bars; also simultaneous H/V falling edge
    MODE = 2'b01;
    start_phase();
    step(0, 0);
    check("sim_h_pos", 32'(dut.h_pos_q), 32'h0);
    check("sim_v_pos", 32'(dut.v_pos_q), 32'h0);
    check("sim_state", 32'(dut.state_q), 32'h1);
    check("sim_frame_cnt", 32'(dut.frame_cnt_q), 32'h2);
    run(0, 1, LINES);
    check("bar_bad", 32'(bad), 32'h0);
    check("bar_px0", 32'(line0[0]), 32'hFFF);
    check("bar_px9", 32'(line0[9]), 32'hFFF);
    check("bar_px10", 32'(line0[10]), 32'hFF0);
    check("bar_px19", 32'(line0[19]), 32'hFF0);
    check("bar_px20", 32'(line0[20]), 32'h0FF);
    check("bar_px69", 32'(line0[69]), 32'h00F);
    check("bar_px70", 32'(line0[70]), 32'h000);
    check("bar_px79", 32'(line0[79]), 32'h000);

    // Frame 3: solid 123, MODE/COLOR changed mid-frame
    MODE = 2'b00; COLOR = 12'h123;
    start_phase();
    run(0, 0, 6);
    MODE = 2'b10; COLOR = 12'h0F0;
    run(6, 0, LINES);
    check("midchg_bad", 32'(bad), 32'h0);
    check("midchg_active_cnt", 32'(act_cnt), 32'd640);
    check("midchg_px32", 32'(line0[32]), 32'h123);

    // Frame 4: checkerboard takes effect
    start_phase();
    run(0, 0, LINES);
    check("chk_bad", 32'(bad), 32'h0);
    check("chk_px0", 32'(line0[0]), 32'h000);
    check("chk_px31", 32'(line0[31]), 32'h000);
    check("chk_px32", 32'(line0[32]), 32'hFFF);
    check("chk_px64", 32'(line0[64]), 32'h000);

    // Frame 5: gradient, B carries frame count 5
    MODE = 2'b11;
    start_phase();
    run(0, 0, LINES);
    check("grad_bad", 32'(bad), 32'h0);
    check("grad_px63", 32'(line0[63]), 32'h005);
    check("grad_px64", 32'(line0[64]), 32'h105);

    // Frame 6: reset in the middle of an active pixel run
    MODE = 2'b01;
    start_phase();
    run(0, 0, 6);
    for (int c = 0; c < 50; c++) step(6, c);
    check("pre_rst_active", 32'(ACTIVE), 32'h1);
    check("pre_rst_rgb", 32'({R_OUT, G_OUT, B_OUT}), 32'h0FF);
    RST = 1'b1;
    #1;
    check("arst_rgb", 32'({R_OUT, G_OUT, B_OUT}), 32'h0);
    check("arst_active", 32'(ACTIVE), 32'h0);
    check("arst_hs_out", 32'(H_SYNC_OUT), 32'h1);
    check("arst_vs_out", 32'(V_SYNC_OUT), 32'h1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    start_phase();
    run(6, 50, LINES);
    check("post_rst_bad", 32'(bad), 32'h0);
    check("post_rst_active", 32'(act_cnt), 32'h0);

    // Frame 7: recovery on the next V_SYNC edge
    MODE = 2'b00; COLOR = 12'h777;
    start_phase();
    run(0, 0, LINES);
    check("recover_bad", 32'(bad), 32'h0);
    check("recover_active_cnt", 32'(act_cnt), 32'd640);
    check("recover_px40", 32'(line0[40]), 32'h777);
    check("recover_frame_cnt", 32'(dut.frame_cnt_q), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_pattern_gen.md
PIXEL_PATTERN_GEN -- requirements
Module: pixel_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACT_START, default 144, meaning clocks from H_SYNC falling edge to first active pixel.
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-003 SHALL have parameter V_ACT_START, default 35, meaning lines from V_SYNC falling edge to first active line.
REQ-004 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-005 SHALL have parameter BAR_WIDTH, default 80, meaning pixels per colour bar.
REQ-006 SHALL have ports: CLK in 1 pixel clock; RST in 1 reset, asynchronous, active-high.
REQ-007 SHALL have ports: H_SYNC in 1, V_SYNC in 1, active-low syncs from the sync controller, synchronous to CLK.
REQ-008 SHALL have ports: MODE in 2 pattern select; COLOR in 12 solid colour {R,G,B} 4 bits each.
REQ-009 SHALL have ports: R_OUT, G_OUT, B_OUT out 4 each; H_SYNC_OUT, V_SYNC_OUT out 1; ACTIVE out 1.

Function
REQ-010 SHALL register H_SYNC/V_SYNC once; a falling edge is prev=1, cur=0.
REQ-011 SHALL keep 10-bit h_pos: cleared to 0 on H_SYNC falling edge, else +1, saturating at 1023.
REQ-012 SHALL keep 10-bit v_pos: cleared on V_SYNC falling edge, else +1 on each H_SYNC falling edge, saturating at 1023.
REQ-013 SHALL, on simultaneous H and V falling edges, clear both counters (V wins over the v_pos increment).
REQ-014 SHALL run FSM WAIT_FRAME -> V_BLANK -> H_BLANK <-> ACT_LINE -> V_BLANK.
REQ-015 SHALL leave WAIT_FRAME only on first V_SYNC falling edge after reset, entering V_BLANK.
REQ-016 SHALL go V_BLANK -> H_BLANK when v_pos = V_ACT_START.
REQ-017 SHALL go H_BLANK -> ACT_LINE when h_pos = H_ACT_START; ACT_LINE -> H_BLANK when h_pos = H_ACT_START+H_ACTIVE-1.
REQ-018 SHALL go to V_BLANK from any state except WAIT_FRAME on V_SYNC falling edge, and from H_BLANK when v_pos = V_ACT_START+V_ACTIVE.
REQ-019 SHALL define pixel x = h_pos-H_ACT_START, y = v_pos-V_ACT_START during ACT_LINE.
REQ-020 SHALL sample MODE and COLOR only on V_SYNC falling edge; mid-frame changes take effect next frame.
REQ-021 SHALL keep bar index 0..7: cleared at ACT_LINE entry, +1 every BAR_WIDTH active pixels, wrapping 7->0.
REQ-022 SHALL output, MODE 00: COLOR.
REQ-023 SHALL output, MODE 01: bar index 0..7 -> {R,G,B} bits 111,110,011,010,101,100,001,000, each bit expanded to 4'hF/4'h0.
REQ-024 SHALL output, MODE 10: white (FFF) when x[5]^y[5]=1, else black.
REQ-025 SHALL output, MODE 11: R=x[9:6], G=y[8:5], B=frame_cnt[3:0]; frame_cnt is 4-bit, +1 per V_SYNC falling edge, wraps.
REQ-026 SHALL drive RGB = 0 whenever state is not ACT_LINE.
REQ-027 SHALL register RGB and ACTIVE so they appear 2 CLK after the H_SYNC/V_SYNC sample that produced them.
REQ-028 SHALL delay H_SYNC/V_SYNC by exactly 2 registers to H_SYNC_OUT/V_SYNC_OUT, aligned with RGB.

Reset
REQ-029 SHALL, on RST high, immediately force: state WAIT_FRAME, counters/bar/frame_cnt 0, RGB 0, ACTIVE 0, H_SYNC_OUT 1, V_SYNC_OUT 1, sync history 1.
REQ-030 SHALL treat RST mid-line as abandoning the frame; output stays blank until the next V_SYNC falling edge after release.

Verification
REQ-031 SHALL verify: reset release, drive 800-clk lines (H_SYNC low 96) without V_SYNC edge -> RGB 0, ACTIVE 0 throughout.
REQ-032 SHALL verify: MODE 00, COLOR 12'hA5C, full frame -> ACTIVE high for exactly 640x480 pixels, RGB A/5/C there, 0 elsewhere.
REQ-033 SHALL verify: MODE 01 -> active pixels 0-79 FFF, 80-159 FF0, 560-639 000; first active pixel RGB 2 CLK after h_pos=144 sample.
REQ-034 SHALL verify: MODE changed 00->10 mid-frame -> current frame stays solid, next frame checkerboard, pixel (32,0) white.
REQ-035 SHALL verify: H and V falling in same cycle -> v_pos 0, h_pos 0, state V_BLANK, frame_cnt +1.
REQ-036 SHALL verify: RST asserted during active pixel -> RGB 0 and syncs_out 1 same cycle, before next CLK edge.
